// File: rtl/timer_sequencer.sv
// timer_sequencer: walks an 8-entry table of (duration, level) segments,
// driving an external compare timer once per segment and optionally looping
// over the table. All outputs are decoded from registered state and index.
module timer_sequencer (
    input  logic        timeclk,
    input  logic        reset,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_addr,
    input  logic [15:0] cfg_dur,
    input  logic [1:0]  cfg_lvl,
    input  logic [2:0]  seg_last,
    input  logic [7:0]  loop_cnt,
    input  logic        start,
    input  logic        abort,
    output logic        tmr_reset,
    output logic [15:0] tmr_datain,
    output logic        tmr_work,
    input  logic        tmr_timeup,
    output logic [1:0]  phase,
    output logic [2:0]  seg_idx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {IDLE, ARM, RUN, NEXT, DONE} state_t;

    state_t      state, state_nxt;
    logic [2:0]  idx, idx_nxt;
    logic [2:0]  last_r, last_nxt;
    logic [7:0]  loops_left, loops_nxt;
    logic [15:0] dur [8];
    logic [1:0]  lvl [8];
    logic        seg_active;

    // Segment table; writes only land while the sequencer is idle.
    always_ff @(posedge timeclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                dur[i] <= '0;
                lvl[i] <= '0;
            end
        end else if (cfg_we && state == IDLE) begin
            dur[cfg_addr] <= cfg_dur;
            lvl[cfg_addr] <= cfg_lvl;
        end
    end

    // Control registers.
    always_ff @(posedge timeclk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            last_r     <= '0;
            loops_left <= '0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            last_r     <= last_nxt;
            loops_left <= loops_nxt;
        end
    end

    // Next-state logic; abort overrides everything once a run is in flight.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        last_nxt  = last_r;
        loops_nxt = loops_left;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt = ARM;
                    idx_nxt   = '0;
                    last_nxt  = seg_last;
                    loops_nxt = loop_cnt;
                end
            end
            ARM:  state_nxt = RUN;
            RUN:  if (tmr_timeup) state_nxt = NEXT;
            NEXT: begin
                if (idx < last_r) begin
                    idx_nxt   = idx + 3'd1;
                    state_nxt = ARM;
                end else if (loops_left != 8'd0) begin
                    loops_nxt = loops_left - 8'd1;
                    idx_nxt   = '0;
                    state_nxt = ARM;
                end else begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
        if (abort && state != IDLE) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
        end
    end

    // Output decode from registered state and index only.
    always_comb begin
        seg_active = (state == ARM) || (state == RUN) || (state == NEXT);
        busy       = (state != IDLE);
        done       = (state == DONE);
        tmr_reset  = (state == IDLE) || (state == ARM) || (state == DONE);
        tmr_work   = (state != RUN);
        tmr_datain = seg_active ? dur[idx] : 16'd0;
        phase      = seg_active ? lvl[idx] : 2'd0;
        seg_idx    = idx;
    end

endmodule

// File: tb/tb_timer_sequencer.sv
// Self-checking bench for timer_sequencer: a behavioural compare-timer model
// plus a segment-level expected-trace model built from the table shadow.
module tb_timer_sequencer;

    logic        timeclk = 1'b0;
    logic        reset;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [15:0] cfg_dur = '0;
    logic [1:0]  cfg_lvl = '0;
    logic [2:0]  seg_last = '0;
    logic [7:0]  loop_cnt = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        tmr_reset;
    logic [15:0] tmr_datain;
    logic        tmr_work;
    logic        tmr_timeup = 1'b0;
    logic [1:0]  phase;
    logic [2:0]  seg_idx;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    // Shadow of what the table should contain.
    logic [15:0] tdur [8];
    logic [1:0]  tlvl [8];

    typedef struct packed {
        logic        rst;
        logic        work;
        logic [15:0] din;
        logic [1:0]  ph;
        logic [2:0]  idx;
        logic        chk_idx;
        logic        bsy;
        logic        dn;
    } exp_t;

    timer_sequencer dut (
        .timeclk(timeclk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_dur(cfg_dur), .cfg_lvl(cfg_lvl), .seg_last(seg_last), .loop_cnt(loop_cnt),
        .start(start), .abort(abort), .tmr_reset(tmr_reset), .tmr_datain(tmr_datain),
        .tmr_work(tmr_work), .tmr_timeup(tmr_timeup), .phase(phase), .seg_idx(seg_idx),
        .busy(busy), .done(done)
    );

    always #5 timeclk = ~timeclk;

    // External timer: async clear, counts while work=0, sticky timeup on match.
    logic [15:0] tcount = '0;
    always @(posedge timeclk or posedge tmr_reset) begin
        if (tmr_reset) begin
            tcount     <= '0;
            tmr_timeup <= 1'b0;
        end else if (!tmr_work) begin
            if (tcount == tmr_datain) tmr_timeup <= 1'b1;
            else                      tcount     <= tcount + 16'd1;
        end
    end

    task automatic cfg_write(input int a, input int d, input int l);
        @(negedge timeclk);
        cfg_we = 1'b1; cfg_addr = 3'(a); cfg_dur = 16'(d); cfg_lvl = 2'(l);
        @(negedge timeclk);
        cfg_we = 1'b0;
        tdur[a] = 16'(d);
        tlvl[a] = 2'(l);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        total++;
        if ({tmr_reset, tmr_work, tmr_datain, phase, seg_idx, busy, done} !== {1'b1, 1'b1, 16'd0, 2'd0, 3'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_now: got rst=%b work=%b din=%0d ph=%0d idx=%0d busy=%b done=%b, want 1 1 0 0 0 0 0",
                     tmr_reset, tmr_work, tmr_datain, phase, seg_idx, busy, done);
        end
        repeat (3) @(negedge timeclk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin tdur[i] = '0; tlvl[i] = '0; end
        @(negedge timeclk);
        total++;
        if ({tmr_reset, tmr_work, tmr_datain, phase, seg_idx, busy, done} !== {1'b1, 1'b1, 16'd0, 2'd0, 3'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_after: got rst=%b work=%b din=%0d ph=%0d idx=%0d busy=%b done=%b, want 1 1 0 0 0 0 0",
                     tmr_reset, tmr_work, tmr_datain, phase, seg_idx, busy, done);
        end
    endtask

    // Starts a run and checks every cycle against the segment-level model.
    // At cycle 'inject' (if >= 0) a table write to entry 0 and a second start
    // are driven; both must be ignored because the sequencer is busy.
    task automatic test_run(input string name, input int last, input int loops, input int inject);
        exp_t q[$];
        exp_t e;
        for (int p = 0; p <= loops; p++) begin
            for (int i = 0; i <= last; i++) begin
                int d = int'(tdur[i]);
                for (int k = 0; k < d + 4; k++) begin
                    e.rst = (k == 0); e.work = (k == 0) || (k == d + 3);
                    e.din = tdur[i]; e.ph = tlvl[i]; e.idx = 3'(i); e.chk_idx = 1'b1;
                    e.bsy = 1'b1; e.dn = 1'b0;
                    q.push_back(e);
                end
            end
        end
        e = '{rst: 1'b1, work: 1'b1, din: 16'd0, ph: 2'd0, idx: 3'd0, chk_idx: 1'b0, bsy: 1'b1, dn: 1'b1};
        q.push_back(e);
        e.bsy = 1'b0; e.dn = 1'b0;
        q.push_back(e);

        @(negedge timeclk);
        seg_last = 3'(last); loop_cnt = 8'(loops); start = 1'b1;
        @(negedge timeclk);
        start = 1'b0;
        foreach (q[c]) begin
            total++;
            if ({tmr_reset, tmr_work, tmr_datain, phase, busy, done} !==
                {q[c].rst, q[c].work, q[c].din, q[c].ph, q[c].bsy, q[c].dn} ||
                (q[c].chk_idx && seg_idx !== q[c].idx)) begin
                bad++;
                $display("FAIL %s cycle %0d: got rst=%b work=%b din=%0d ph=%0d idx=%0d busy=%b done=%b, want rst=%b work=%b din=%0d ph=%0d idx=%0d busy=%b done=%b",
                         name, c, tmr_reset, tmr_work, tmr_datain, phase, seg_idx, busy, done,
                         q[c].rst, q[c].work, q[c].din, q[c].ph, q[c].idx, q[c].bsy, q[c].dn);
            end
            if (c == inject) begin
                cfg_we = 1'b1; cfg_addr = 3'd0; cfg_dur = 16'd100; cfg_lvl = 2'd0; start = 1'b1;
            end
            @(negedge timeclk);
            cfg_we = 1'b0; start = 1'b0;
        end
    endtask

    task automatic test_two_seg();
        cfg_write(0, 5, 1);
        cfg_write(1, 10, 2);
        test_run("two_seg", 1, 0, -1);
    endtask

    task automatic test_loop();
        cfg_write(0, 3, 3);
        test_run("loop3", 0, 2, -1);
    endtask

    task automatic test_dur0();
        cfg_write(0, 0, 2);
        test_run("dur0", 0, 0, -1);
    endtask

    task automatic test_busy_write();
        cfg_write(0, 7, 3);
        test_run("busy_write", 0, 0, 4);
        test_run("after_busy_write", 0, 0, -1);
    endtask

    task automatic test_abort();
        cfg_write(0, 4, 1);
        cfg_write(1, 6, 2);
        // start and abort together in IDLE: abort wins
        @(negedge timeclk);
        seg_last = 3'd1; loop_cnt = 8'd0; start = 1'b1; abort = 1'b1;
        @(negedge timeclk);
        start = 1'b0; abort = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL abort_start_idle: busy=%b want 0", busy);
        end
        start = 1'b1;
        @(negedge timeclk);
        start = 1'b0;
        // segment 0 spans cycles 0..7, segment 1 ARM at 8, RUN from 9
        repeat (10) @(negedge timeclk);
        total++;
        if ({tmr_work, phase, seg_idx, busy} !== {1'b0, 2'd2, 3'd1, 1'b1}) begin
            bad++;
            $display("FAIL abort_in_run: got work=%b ph=%0d idx=%0d busy=%b, want 0 2 1 1",
                     tmr_work, phase, seg_idx, busy);
        end
        abort = 1'b1;
        @(negedge timeclk);
        abort = 1'b0;
        total++;
        if ({tmr_reset, tmr_work, tmr_datain, phase, seg_idx, busy, done} !== {1'b1, 1'b1, 16'd0, 2'd0, 3'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL abort_idle: got rst=%b work=%b din=%0d ph=%0d idx=%0d busy=%b done=%b, want 1 1 0 0 0 0 0",
                     tmr_reset, tmr_work, tmr_datain, phase, seg_idx, busy, done);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge timeclk);
            total++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                bad++; $display("FAIL abort_no_done: cycle %0d done=%b busy=%b want 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_async_reset();
        cfg_write(0, 9, 1);
        cfg_write(2, 5, 3);
        @(negedge timeclk);
        seg_last = 3'd2; loop_cnt = 8'd0; start = 1'b1;
        @(negedge timeclk);
        start = 1'b0;
        repeat (3) @(negedge timeclk);
        #1 reset = 1'b1;
        #1;
        total++;
        if ({tmr_reset, tmr_work, tmr_datain, phase, seg_idx, busy, done} !== {1'b1, 1'b1, 16'd0, 2'd0, 3'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL async_reset: got rst=%b work=%b din=%0d ph=%0d idx=%0d busy=%b done=%b, want 1 1 0 0 0 0 0",
                     tmr_reset, tmr_work, tmr_datain, phase, seg_idx, busy, done);
        end
        @(negedge timeclk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin tdur[i] = '0; tlvl[i] = '0; end
        test_run("after_reset", 2, 0, -1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < 8; a++)
                cfg_write(a, int'($urandom_range(0, 12)), int'($urandom_range(0, 3)));
            test_run($sformatf("rand%0d", r), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 2)), -1);
        end
    endtask

    initial begin
        test_reset();
        test_two_seg();
        test_loop();
        test_dur0();
        test_busy_write();
        test_abort();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
